fp_mul_int_vec_seq: RTL and testbench

- Time-multiplexes one shared fp_mul_int datapath (FP16 x intN -> FP32, combinational) across a NUM_LANES-wide operand vector.
- Accepts a full vector on a valid/ready handshake and registers it.
- Feeds one lane per cycle to the external multiplier and collects each result into a result register.
- Presents the complete FP32 vector on an output valid/ready handshake; sits between the streamer and the multiplier in the versacore FP*INT path.

---
 rtl/fp_mul_int_vec_seq.sv | 72 +++++++
 tb/tb_fp_mul_int_vec_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_int_vec_seq.sv
// fp_mul_int_vec_seq: feeds a registered operand vector one lane per cycle through a shared FP16 x intN multiplier
module fp_mul_int_vec_seq #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 4,
  parameter int WIDTH_OUT = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [NUM_LANES*WIDTH_A-1:0]   in_a_i,
  input  logic [NUM_LANES*WIDTH_B-1:0]   in_b_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_LANES*WIDTH_OUT-1:0] out_result_o,
  output logic [WIDTH_A-1:0]             mul_a_o,
  output logic [WIDTH_B-1:0]             mul_b_o,
  input  logic [WIDTH_OUT-1:0]           mul_result_i,
  output logic                           busy_o,
  output logic [CNT_WIDTH-1:0]           mul_count_o
);
  localparam int LW = $clog2(NUM_LANES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [LW-1:0] lane;
  logic [NUM_LANES*WIDTH_A-1:0] a_q;
  logic [NUM_LANES*WIDTH_B-1:0] b_q;
  logic [NUM_LANES*WIDTH_OUT-1:0] res_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic accept, last;
  // handshake decode and next state; a DONE vector is released in the same cycle a new one is taken
  always_comb begin
    in_ready_o = (state == IDLE) || (state == DONE && out_ready_i);
    accept = in_valid_i && in_ready_o;
    last = lane == LW'(NUM_LANES - 1);
    state_nx = accept ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE && out_ready_i) ? IDLE : state;
  end
  assign out_valid_o  = state == DONE;
  assign busy_o       = state != IDLE;
  assign out_result_o = res_q;
  assign mul_count_o  = cnt_q;
  assign mul_a_o      = a_q[lane*WIDTH_A +: WIDTH_A];
  assign mul_b_o      = b_q[lane*WIDTH_B +: WIDTH_B];
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  // operand capture, lane-by-lane result collection and saturating multiply count
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      lane  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        a_q  <= in_a_i;
        b_q  <= in_b_i;
        lane <= '0;
      end
      if (state == RUN) begin
        res_q[lane*WIDTH_OUT +: WIDTH_OUT] <= mul_result_i;
        lane <= last ? '0 : lane + 1'b1;
        if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
      end
    end
endmodule

// File: tb/tb_fp_mul_int_vec_seq.sv
// tb_fp_mul_int_vec_seq: directed vectors checked against a transaction-level model with a bench-side FP16 x int4 multiplier
module tb_fp_mul_int_vec_seq;
  localparam int N = 4;
  logic clk = 0;
  logic rst_n = 1;
  logic in_valid = 0, out_ready = 0;
  logic [N*16-1:0] in_a = '0;
  logic [N*4-1:0] in_b = '0;
  logic in_ready, out_valid, busy;
  logic [N*32-1:0] out_result;
  logic [15:0] mul_a;
  logic [3:0] mul_b;
  logic [31:0] mul_result, mul_count;
  logic s_in_ready, s_out_valid, s_busy;
  logic [N*32-1:0] s_out_result;
  logic [15:0] s_mul_a;
  logic [3:0] s_mul_b;
  logic [31:0] s_mul_result;
  logic [3:0] s_mul_count;
  int pass = 0, total = 0;
  bit b2b = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] fpmul(input logic [15:0] a, input logic [3:0] b);
    int bi, mb, e, k, pi;
    logic s;
    logic [31:0] m;
    bi = int'($signed(b));
    mb = bi < 0 ? -bi : bi;
    s = a[15] ^ (bi < 0);
    if (a[14:10] == 5'h1F) return (a[9:0] != 0 || mb == 0) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
    e = a[14:10] == 0 ? -14 : int'(a[14:10]) - 15;
    pi = ((a[14:10] != 0) ? 1024 : 0) + int'(a[9:0]);
    pi = pi * mb;
    if (pi == 0) return {s, 31'h0};
    k = 0;
    for (int i = 0; i < 15; i++) if (((pi >> i) & 1) != 0) k = i;
    m = 32'(pi) << (23 - k);
    return {s, 8'(k + e - 10 + 127), m[22:0]};
  endfunction

  function automatic logic [N*32-1:0] vexp(input logic [N*16-1:0] a, input logic [N*4-1:0] b);
    logic [N*32-1:0] r;
    for (int l = 0; l < N; l++) r[l*32 +: 32] = fpmul(a[l*16 +: 16], b[l*4 +: 4]);
    return r;
  endfunction

  assign mul_result = fpmul(mul_a, mul_b);
  assign s_mul_result = fpmul(s_mul_a, s_mul_b);

  fp_mul_int_vec_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_result_i(mul_result), .busy_o(busy), .mul_count_o(mul_count)
  );

  fp_mul_int_vec_seq #(.CNT_WIDTH(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .out_result_o(s_out_result), .mul_a_o(s_mul_a), .mul_b_o(s_mul_b),
    .mul_result_i(s_mul_result), .busy_o(s_busy), .mul_count_o(s_mul_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // transaction model: lanes still to multiply, whether a finished vector is waiting, total multiplies
  int m_left, m_cnt;
  bit m_done;
  logic [N*16-1:0] m_a;
  logic [N*4-1:0] m_b;
  logic [N*32-1:0] m_exp;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left <= 0; m_cnt <= 0; m_done <= 0; m_a <= '0; m_b <= '0; m_exp <= '0;
    end else begin
      if (m_left > 0) begin
        m_left <= m_left - 1;
        m_cnt <= m_cnt + 1;
        m_done <= m_left == 1;
      end else if (m_done && out_ready) m_done <= 0;
      if (in_valid && m_left == 0 && (!m_done || out_ready)) begin
        m_a <= in_a; m_b <= in_b; m_exp <= vexp(in_a, in_b);
        m_left <= N; m_done <= 0;
      end
    end

  // per-cycle comparison against the model
  int cyc = 0, last_rise = -1;
  logic prev_valid = 0;
  always @(negedge clk) begin
    int idx;
    cyc++;
    idx = m_left > 0 ? N - m_left : 0;
    chk("in_ready", in_ready, m_left == 0 && (!m_done || out_ready));
    chk("out_valid", out_valid, m_done);
    chk("busy", busy, m_left > 0 || m_done);
    chk("mul_count", mul_count, 32'(m_cnt));
    chk("mul_count_sat4", s_mul_count, m_cnt > 15 ? 4'hF : 4'(m_cnt));
    chk("mul_a", mul_a, m_a[idx*16 +: 16]);
    chk("mul_b", mul_b, m_b[idx*4 +: 4]);
    if (m_done) chk("out_result", out_result, m_exp);
    if (out_valid && !prev_valid) begin
      if (b2b && last_rise >= 0) chk("valid_spacing", cyc - last_rise, 5);
      last_rise = b2b ? cyc : -1;
    end
    prev_valid = out_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [N*16-1:0] a, input logic [N*4-1:0] b);
    logic r = 0;
    in_a = a; in_b = b; in_valid = 1;
    for (int i = 0; i < 60 && !r; i++) begin
      #1 r = in_ready;
      @(posedge clk);
      #2;
    end
    if (!r) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  logic [N*16-1:0] ta[13];
  logic [N*4-1:0] tb[13];
  int lat;

  initial begin
    ta[0] = {16'h7C00, 16'h0000, 16'h3E00, 16'h3C00};
    tb[0] = {4'h0, 4'h5, 4'hE, 4'h3};
    for (int i = 1; i < 13; i++) begin
      ta[i] = {16'(16'h3800 + i*16'h0123), 16'(16'hB400 ^ i*16'h0042), 16'(16'h0200 + i), 16'(16'h4A00 - i*16'h0100)};
      tb[i] = 16'(16'h8F71 + i*16'h1357);
    end
    ta[5][31:16] = 16'h7E01;
    ta[6][15:0] = 16'hFC00;
    #1 rst_n = 0;
    step(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_count", mul_count, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_mul_a", mul_a, 0);
    rst_n = 1;
    step(1);
    // single vector, held in DONE until inspected
    send(ta[0], tb[0]);
    in_valid = 0;
    wait_valid(lat);
    chk("latency", lat, 5);
    chk("lit_result", out_result, 128'h7FC00000_00000000_C0400000_40400000);
    chk("lit_count", mul_count, 4);
    step(1);
    out_ready = 1;
    step(2);
    chk("lit_idle", busy, 0);
    // back-to-back with in_valid held high
    b2b = 1;
    for (int i = 1; i <= 4; i++) send(ta[i], tb[i]);
    in_valid = 0;
    step(8);
    b2b = 0;
    // output backpressure with a pending vector
    out_ready = 0;
    send(ta[5], tb[5]);
    in_a = ta[6]; in_b = tb[6];
    step(6);
    step(10);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1;
    send(ta[6], tb[6]);
    chk("bp_accepted", {busy, out_valid}, 2'b10);
    in_valid = 0;
    step(8);
    // reset after two lanes of a vector
    send(ta[7], tb[7]);
    in_valid = 0;
    step(2);
    rst_n = 0;
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_result", out_result, 0);
    chk("rst_mid_busy", busy, 0);
    step(1);
    rst_n = 1;
    send(ta[8], tb[8]);
    in_valid = 0;
    wait_valid(lat);
    chk("post_rst_latency", lat, 5);
    step(1);
    // five vectors since reset saturate a 4-bit counter
    for (int i = 9; i <= 12; i++) send(ta[i], tb[i]);
    in_valid = 0;
    step(8);
    chk("lit_sat4", s_mul_count, 4'hF);
    chk("lit_count20", mul_count, 20);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
